uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Shares one UART transmit line between two byte requesters and owns the baud-select setting of the UART baud rate generator. Consumes the generator's one-cycle 16x-oversample pulse, frames each granted byte as start/8 data/stop (LSB first), and round-robins between requesters. Baud changes are accepted at any time and applied only between frames, so no frame is sent at mixed rates. Sits between host-side command logic and the baud generator / TXD pad in the IO_SIF block.

Parameters:
P_OVS, 16, baud ticks per bit period (4-bit tick counter; legal range 2..16)
P_STOP_BITS, 1, stop bits per frame (1 or 2)
P_RST_BAUD, 2'b11, BAUD_CTRL value after reset (matches the generator's reset rate)

Ports:
FPGA_CLK  in  1  system clock
FPGA_RST  in  1  reset, asynchronous, active-high
BAUD_TICK  in  1  16x baud pulse from the baud generator, one cycle wide
BAUD_SEL  in  2  requested baud select (00 9600, 01 19200, 10 38400, 11 max)
BAUD_SEL_WE  in  1  write strobe for BAUD_SEL
BAUD_CTRL  out  2  applied baud select, drives the generator
REQ0_VALID  in  1  requester 0 has a byte
REQ0_DATA  in  8  requester 0 byte
REQ0_READY  out  1  requester 0 byte accepted this cycle
REQ1_VALID / REQ1_DATA / REQ1_READY  same as requester 0, for requester 1
UART_TXD  out  1  serial output, idle high
TX_BUSY  out  1  frame in progress (state != IDLE)
GRANT_ID  out  1  requester index of the current/last frame

Behaviour:
- Reset (async): state IDLE, UART_TXD=1, TX_BUSY=0, REQx_READY=0, GRANT_ID=1, last-served pointer=1, BAUD_CTRL=P_RST_BAUD, pend_valid=0, counters=0.
- Baud config: BAUD_SEL_WE=1 loads pend_sel and sets pend_valid in any state; the latest write wins. In IDLE with pend_valid=1: BAUD_CTRL<=pend_sel, pend_valid<=0, and no grant that cycle. A write and an apply in the same cycle keep the new value pending.
- Arbitration (IDLE, pend_valid=0): if exactly one VALID is high, grant it. If both are high, grant the one not equal to the last-served pointer.
- REQx_READY is combinational: high only in IDLE for the winner. Transfer occurs when VALID&READY are high at the clock edge. On transfer, latch the data into the shift register, set GRANT_ID and the pointer, and go to START. Requesters must hold VALID and DATA until READY.
- START: UART_TXD=0 from the cycle after acceptance. tick_cnt counts BAUD_TICK pulses. On the P_OVS-th tick, clear tick_cnt and go to DATA.
- DATA: UART_TXD=shift[0]. Every P_OVS ticks, shift right and increment bit_cnt. After 8 bits, go to STOP.
- STOP: UART_TXD=1 for P_STOP_BITS*P_OVS ticks, then go to IDLE. A new grant is possible the same cycle IDLE is entered only if pend_valid=0; else the baud apply takes priority for one cycle.
- The first bit period is measured in ticks, not aligned to the tick phase; its duration may be up to one tick period short.
- No BAUD_TICK: the FSM holds its state indefinitely. UART_TXD and TX_BUSY stay stable.
- BAUD_TICK in the acceptance cycle is not counted.
- VALID dropping before READY is legal; no transfer occurs.
- Reset mid-frame: immediate return to the reset values. The partial frame is abandoned, and UART_TXD goes high asynchronously.
- TX_BUSY=1 in START, DATA and STOP.
- Latency: acceptance to start-bit edge is 1 cycle. With P_STOP_BITS=1, a frame lasts 10*P_OVS ticks.

Test Plan:
1. Single frame: BAUD_TICK every cycle, REQ0 sends 0xA5. REQ0_READY pulses 1 cycle. Then, from the next cycle, UART_TXD carries 16-cycle bits 0,1,0,1,0,0,1,0,1,1. TX_BUSY is high for 160 cycles and GRANT_ID=0.
2. Contention: after reset, both VALID high with REQ0=0x11 and REQ1=0x22, held until served. Order is 0x11 (GRANT_ID=0) then 0x22 (GRANT_ID=1). With both re-asserted, the next grant is 0.
3. Baud change mid-frame: at bit 3 of a frame, write BAUD_SEL=01. BAUD_CTRL stays 11 until the frame ends. In the first IDLE cycle BAUD_CTRL=01 with READY low. The next frame is granted one cycle later.
4. Tick stall: stop BAUD_TICK during DATA bit 4 for 100 cycles. UART_TXD holds the bit value, and the frame resumes with the correct remaining ticks.
5. Async reset mid-frame: assert FPGA_RST between clock edges during DATA. UART_TXD=1, TX_BUSY=0 and BAUD_CTRL=11 without waiting for a clock edge. After release, a fresh 0x3C frame is correct.
6. P_STOP_BITS=2: frame 0xFF gives a start low of 16 ticks, then high for 8*16+32 ticks. TX_BUSY falls after 176 ticks.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Shares one UART transmit line between two byte requesters and owns the
//   baud-select setting of the baud generator. Frames are start / 8 data
//   (LSB first) / P_STOP_BITS stop bits. Bit periods are timed in BAUD_TICK
//   pulses (P_OVS per bit). Requesters are served round-robin. Baud changes
//   are held pending and applied only while idle, so a frame never mixes
//   rates.
//
// Ports
//   FPGA_CLK, FPGA_RST          clock, async active-high reset
//   BAUD_TICK                   one-cycle oversample pulse from the generator
//   BAUD_SEL, BAUD_SEL_WE       requested baud select and its write strobe
//   BAUD_CTRL                   applied baud select, drives the generator
//   REQx_VALID/DATA/READY       byte requesters 0 and 1 (valid/ready)
//   UART_TXD                    serial output, idle high
//   TX_BUSY                     frame in progress
//   GRANT_ID                    requester index of current/last frame
module uart_tx_sched #(
  parameter int unsigned P_OVS       = 16,
  parameter int unsigned P_STOP_BITS = 1,
  parameter logic [1:0]  P_RST_BAUD  = 2'b11
) (
  input  logic       FPGA_CLK,
  input  logic       FPGA_RST,
  input  logic       BAUD_TICK,
  input  logic [1:0] BAUD_SEL,
  input  logic       BAUD_SEL_WE,
  output logic [1:0] BAUD_CTRL,
  input  logic       REQ0_VALID,
  input  logic [7:0] REQ0_DATA,
  output logic       REQ0_READY,
  input  logic       REQ1_VALID,
  input  logic [7:0] REQ1_DATA,
  output logic       REQ1_READY,
  output logic       UART_TXD,
  output logic       TX_BUSY,
  output logic       GRANT_ID
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [3:0] TICK_LAST = 4'(P_OVS - 1);
  localparam logic [2:0] STOP_LAST = 3'(P_STOP_BITS - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] shift_q;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic       grant_q;     // also the last-served pointer
  logic [1:0] baud_q;
  logic [1:0] pend_sel;
  logic       pend_valid;

  logic       win_id;
  logic       win_valid;
  logic       can_grant;
  logic       xfer;
  logic       period_end;
  logic       idle;

  // Arbitration: a lone requester wins; on contention the one not served
  // last wins.
  always_comb begin
    win_valid = REQ0_VALID | REQ1_VALID;
    if (REQ0_VALID && REQ1_VALID) begin
      win_id = ~grant_q;
    end else if (REQ1_VALID) begin
      win_id = 1'b1;
    end else begin
      win_id = 1'b0;
    end
  end

  assign idle       = (state == S_IDLE);
  // A pending baud apply takes the idle cycle; no grant alongside it.
  assign can_grant  = idle && !pend_valid && !FPGA_RST;
  assign xfer       = can_grant && win_valid;
  assign period_end = BAUD_TICK && (tick_cnt == TICK_LAST);

  // State register
  always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
    if (FPGA_RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (xfer) state_nxt = S_START;
      S_START: if (period_end) state_nxt = S_DATA;
      S_DATA:  if (period_end && bit_cnt == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (period_end && bit_cnt == STOP_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: shift register, counters, grant pointer, baud config
  always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
    if (FPGA_RST) begin
      shift_q    <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      grant_q    <= 1'b1;
      baud_q     <= P_RST_BAUD;
      pend_sel   <= P_RST_BAUD;
      pend_valid <= 1'b0;
    end else begin
      // A write in the apply cycle stays pending; the apply uses the
      // previously pending value.
      if (BAUD_SEL_WE) begin
        pend_sel   <= BAUD_SEL;
        pend_valid <= 1'b1;
      end else if (idle && pend_valid) begin
        pend_valid <= 1'b0;
      end
      if (idle && pend_valid) begin
        baud_q <= pend_sel;
      end

      if (xfer) begin
        shift_q  <= win_id ? REQ1_DATA : REQ0_DATA;
        grant_q  <= win_id;
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (!idle && BAUD_TICK) begin
        if (period_end) begin
          tick_cnt <= '0;
          if (state == S_DATA) begin
            shift_q <= {1'b0, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;  // wraps to 0 entering STOP
          end else if (state == S_STOP) begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end else begin
          tick_cnt <= tick_cnt + 4'd1;
        end
      end
    end
  end

  // Outputs; TXD is decoded from state so reset drives it high immediately.
  always_comb begin
    UART_TXD   = 1'b1;
    TX_BUSY    = !idle;
    REQ0_READY = xfer && !win_id;
    REQ1_READY = xfer && win_id;
    unique case (state)
      S_START: UART_TXD = 1'b0;
      S_DATA:  UART_TXD = shift_q[0];
      default: UART_TXD = 1'b1;
    endcase
  end

  assign BAUD_CTRL = baud_q;
  assign GRANT_ID  = grant_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: stimulus pushes expected (grant, byte) pairs
// into a queue; a serial monitor decodes UART_TXD frames by counting
// BAUD_TICK pulses and checks each decoded frame against the queue head.
module tb_uart_tx_sched;

  typedef struct packed {
    logic       gid;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [1:0] sel;
  logic       we;
  logic [1:0] baud;
  logic       v0, v1;
  logic [7:0] d0, d1;
  logic       ready0, ready1;
  logic       txd, busy, gid;

  // second instance with two stop bits
  logic [1:0] sel2;
  logic       we2;
  logic [1:0] baud2;
  logic       v2a, v2b;
  logic [7:0] d2a, d2b;
  logic       ready2a, ready2b;
  logic       txd2, busy2, gid2;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  uart_tx_sched #(.P_OVS(16), .P_STOP_BITS(1), .P_RST_BAUD(2'b11)) u_dut (
    .FPGA_CLK(clk), .FPGA_RST(rst), .BAUD_TICK(tick),
    .BAUD_SEL(sel), .BAUD_SEL_WE(we), .BAUD_CTRL(baud),
    .REQ0_VALID(v0), .REQ0_DATA(d0), .REQ0_READY(ready0),
    .REQ1_VALID(v1), .REQ1_DATA(d1), .REQ1_READY(ready1),
    .UART_TXD(txd), .TX_BUSY(busy), .GRANT_ID(gid)
  );

  uart_tx_sched #(.P_OVS(16), .P_STOP_BITS(2), .P_RST_BAUD(2'b11)) u_dut2 (
    .FPGA_CLK(clk), .FPGA_RST(rst), .BAUD_TICK(tick),
    .BAUD_SEL(sel2), .BAUD_SEL_WE(we2), .BAUD_CTRL(baud2),
    .REQ0_VALID(v2a), .REQ0_DATA(d2a), .REQ0_READY(ready2a),
    .REQ1_VALID(v2b), .REQ1_DATA(d2b), .REQ1_READY(ready2b),
    .UART_TXD(txd2), .TX_BUSY(busy2), .GRANT_ID(gid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  task automatic send(input logic id, input logic [7:0] d);
    logic done;
    done = 1'b0;
    exp_q.push_back('{gid: id, data: d});
    @(negedge clk);
    if (id) begin v1 = 1'b1; d1 = d; end
    else    begin v0 = 1'b1; d0 = d; end
    for (int i = 0; i < 2000 && !done; i++) begin
      #1;
      if ((id ? ready1 : ready0) === 1'b1) begin
        @(posedge clk); #1;
        if (id) v1 = 1'b0; else v0 = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("send_accept", {31'd0, done}, 1);
    if (!done) begin v0 = 1'b0; v1 = 1'b0; end
  endtask

  // Caller is just past a negedge with both valids set.
  task automatic serve_both();
    logic r0, r1;
    for (int i = 0; i < 2000 && (v0 || v1); i++) begin
      r0 = ready0;
      r1 = ready1;
      @(posedge clk); #1;
      if (r0) v0 = 1'b0;
      if (r1) v1 = 1'b0;
      @(negedge clk); #1;
    end
    chk("serve_both_done", {31'd0, v0 | v1}, 0);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < max && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    chk("wait_idle", {31'd0, idle}, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Serial monitor: counts consumed ticks from the start-bit edge and
  // samples each bit at its middle tick.
  initial begin : monitor
    logic       prev_txd;
    logic       active;
    int         c;
    int         s;
    logic [7:0] got;
    exp_t       e;
    prev_txd = 1'b1;
    active   = 1'b0;
    c        = 0;
    s        = 0;
    got      = '0;
    e        = '{gid: 1'b0, data: 8'h00};
    forever begin
      @(negedge clk);
      if (rst) begin
        active   = 1'b0;
        prev_txd = 1'b1;
      end else begin
        if (!active) begin
          if (prev_txd && !txd) begin
            active = 1'b1;
            c      = 0;
            s      = 0;
            got    = '0;
            if (exp_q.size() == 0) begin
              chk("frame_expected", 0, 1);
              e = '{gid: 1'b0, data: 8'h00};
            end else begin
              e = exp_q.pop_front();
            end
            chk("grant_id", {31'd0, gid}, {31'd0, e.gid});
          end
        end else begin
          if (s <= 8 && c == 24 + 16 * s) begin
            if (s < 8) begin
              got[s[2:0]] = txd;
            end else begin
              chk("stop_bit", {31'd0, txd}, 1);
              chk("frame_data", {24'd0, got}, {24'd0, e.data});
            end
            s++;
          end
          if (!busy) begin
            chk("frame_ticks", c, 160);
            active = 1'b0;
          end
        end
        if (active && tick) c++;
        prev_txd = txd;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic ok;
    logic idle;
    int   lo, hi, tot;
    rst = 1'b1; tick = 1'b1; sel = 2'b00; we = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    sel2 = 2'b00; we2 = 1'b0; v2a = 1'b0; v2b = 1'b0; d2a = '0; d2b = '0;

    // Reset state
    #3;
    chk("rst_txd", {31'd0, txd}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready0", {31'd0, ready0}, 0);
    chk("rst_ready1", {31'd0, ready1}, 0);
    chk("rst_grant", {31'd0, gid}, 1);
    chk("rst_baud", {30'd0, baud}, 3);
    chk("rst2_baud", {30'd0, baud2}, 3);
    chk("rst2_grant", {31'd0, gid2}, 1);
    chk("rst2_ready1", {31'd0, ready2b}, 0);
    @(posedge clk); #2 rst = 1'b0;

    // Single frame 0xA5 from requester 0
    send(1'b0, 8'hA5);
    @(negedge clk);
    chk("t1_ready_pulse", {31'd0, ready0}, 0);
    chk("t1_start_low", {31'd0, txd}, 0);
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_grant", {31'd0, gid}, 0);
    wait_idle(400);

    // Contention after reset: 0 first, then 1, then 0 again
    do_reset();
    @(negedge clk);
    v0 = 1'b1; d0 = 8'h11; v1 = 1'b1; d1 = 8'h22;
    exp_q.push_back('{gid: 1'b0, data: 8'h11});
    exp_q.push_back('{gid: 1'b1, data: 8'h22});
    #1;
    chk("t2_ready0_first", {31'd0, ready0}, 1);
    chk("t2_ready1_first", {31'd0, ready1}, 0);
    serve_both();
    wait_idle(400);
    v0 = 1'b1; d0 = 8'h33; v1 = 1'b1; d1 = 8'h44;
    exp_q.push_back('{gid: 1'b0, data: 8'h33});
    exp_q.push_back('{gid: 1'b1, data: 8'h44});
    #1;
    chk("t2_ready0_again", {31'd0, ready0}, 1);
    chk("t2_ready1_again", {31'd0, ready1}, 0);
    serve_both();
    wait_idle(400);

    // Baud change during data bit 3; requester 1 waits for the next frame
    send(1'b0, 8'h5A);
    d1 = 8'h77; v1 = 1'b1;
    exp_q.push_back('{gid: 1'b1, data: 8'h77});
    repeat (70) @(negedge clk);
    sel = 2'b01; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    ok = 1'b1; idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      if (busy) begin
        if (baud !== 2'b11) ok = 1'b0;
      end else begin
        idle = 1'b1;
      end
    end
    chk("t3_baud_held", {31'd0, ok}, 1);
    chk("t3_idle_reached", {31'd0, idle}, 1);
    chk("t3_ready_blocked", {31'd0, ready1}, 0);
    @(negedge clk);
    chk("t3_baud_applied", {30'd0, baud}, 1);
    chk("t3_ready_after", {31'd0, ready1}, 1);
    @(posedge clk); #1 v1 = 1'b0;
    wait_idle(400);

    // Tick stall in data bit 4 of 0xC3 (bit 4 = 0)
    send(1'b0, 8'hC3);
    repeat (86) @(negedge clk);
    @(posedge clk); #1 tick = 1'b0;
    @(negedge clk);
    chk("t4_stall_bit", {31'd0, txd}, 0);
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    chk("t4_stall_hold", {31'd0, ok}, 1);
    @(posedge clk); #1 tick = 1'b1;
    wait_idle(400);

    // Async reset mid-frame (this frame is abandoned)
    send(1'b1, 8'h96);
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_txd", {31'd0, txd}, 1);
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_baud", {30'd0, baud}, 3);
    chk("t5_grant", {31'd0, gid}, 1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    send(1'b0, 8'h3C);
    wait_idle(400);

    // Two stop bits on the second instance
    @(negedge clk);
    v2a = 1'b1; d2a = 8'hFF;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (ready2a === 1'b1) begin
        @(posedge clk); #1 v2a = 1'b0;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("t6_accept", {31'd0, ok}, 1);
    v2a = 1'b0;
    lo = 0; hi = 0; tot = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy2) begin
        tot++;
        if (txd2) hi++; else lo++;
      end
    end
    chk("t6_start_ticks", lo, 16);
    chk("t6_high_ticks", hi, 160);
    chk("t6_busy_ticks", tot, 176);
    chk("t6_grant", {31'd0, gid2}, 0);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
